// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/LS request, response and memory-bridge signals of mem_arbiter
interface mem_arbiter_if #(parameter int ADDR_W = 64, parameter int DATA_W = 64);
  logic              iIfReqValid;
  logic [ADDR_W-1:0] iIfReqAddr;
  logic              oIfReqReady;
  logic              oIfRspValid;
  logic [31:0]       oIfRspData;
  logic              iLsReqValid;
  logic              iLsReqWrEn;
  logic [ADDR_W-1:0] iLsReqAddr;
  logic [DATA_W-1:0] iLsReqData;
  logic [7:0]        iLsReqLen;
  logic              oLsReqReady;
  logic              oLsRspValid;
  logic [DATA_W-1:0] oLsRspData;
  logic              oMemRdEn;
  logic [ADDR_W-1:0] oMemRdAddr;
  logic [7:0]        oMemRdLen;
  logic              oMemWrEn;
  logic [ADDR_W-1:0] oMemWrAddr;
  logic [DATA_W-1:0] oMemWrData;
  logic [7:0]        oMemWrLen;
  logic [DATA_W-1:0] iMemRdData;
  logic              oBusy;
  modport slave (
    input  iIfReqValid, iIfReqAddr, iLsReqValid, iLsReqWrEn, iLsReqAddr, iLsReqData, iLsReqLen, iMemRdData,
    output oIfReqReady, oIfRspValid, oIfRspData, oLsReqReady, oLsRspValid, oLsRspData,
           oMemRdEn, oMemRdAddr, oMemRdLen, oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen, oBusy
  );
  modport master (
    output iIfReqValid, iIfReqAddr, iLsReqValid, iLsReqWrEn, iLsReqAddr, iLsReqData, iLsReqLen, iMemRdData,
    input  oIfReqReady, oIfRspValid, oIfRspData, oLsReqReady, oLsRspValid, oLsRspData,
           oMemRdEn, oMemRdAddr, oMemRdLen, oMemWrEn, oMemWrAddr, oMemWrData, oMemWrLen, oBusy
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between IF and LS; define MEM_ARB_RR_EN for round-robin grant
module mem_arbiter #(
  parameter int LAT    = 1,
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input logic          iClock,
  input logic          iReset,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2;
  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_is_ls, r_wr, r_first;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data, r_ls_data;
  logic [7:0]        r_len;
  logic [31:0]       r_if_data;
  logic              w_idle, w_acc, w_rd, w_grant_ls, w_grant_if, w_hs_ls, w_hs_if;
  logic [DATA_W-1:0] w_mask;
`ifdef MEM_ARB_RR_EN
  logic r_last_ls;
  always_ff @(posedge iClock)
    if (iReset) r_last_ls <= 1'b0;
    else if (w_hs_ls | w_hs_if) r_last_ls <= w_hs_ls;
  assign w_grant_ls = bus.iLsReqValid & (~bus.iIfReqValid | ~r_last_ls);
`else
  assign w_grant_ls = bus.iLsReqValid;
`endif
  assign w_grant_if = bus.iIfReqValid & ~w_grant_ls;
  assign w_idle     = (r_state == IDLE) & ~iReset;
  assign w_acc      = r_state == ACCESS;
  assign w_rd       = w_acc & ~r_wr;
  assign w_hs_ls    = w_idle & w_grant_ls;
  assign w_hs_if    = w_idle & w_grant_if;
  assign w_mask     = r_len == 8'd1 ? DATA_W'(8'hFF) :
                      r_len == 8'd2 ? DATA_W'(16'hFFFF) :
                      r_len == 8'd4 ? DATA_W'(32'hFFFF_FFFF) : '1;
  assign bus.oIfReqReady = w_hs_if;
  assign bus.oLsReqReady = w_hs_ls;
  assign bus.oIfRspValid = (r_state == RESP) & ~r_is_ls;
  assign bus.oLsRspValid = (r_state == RESP) & r_is_ls;
  assign bus.oIfRspData  = r_if_data;
  assign bus.oLsRspData  = r_ls_data;
  assign bus.oMemRdEn    = w_rd;
  assign bus.oMemRdAddr  = w_rd ? r_addr : '0;
  assign bus.oMemRdLen   = w_rd ? r_len : '0;
  assign bus.oMemWrEn    = w_acc & r_wr & r_first;
  assign bus.oMemWrAddr  = w_acc & r_wr ? r_addr : '0;
  assign bus.oMemWrData  = w_acc & r_wr ? r_data : '0;
  assign bus.oMemWrLen   = w_acc & r_wr ? r_len : '0;
  assign bus.oBusy       = r_state != IDLE;
  always_ff @(posedge iClock) begin
    if (iReset) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_is_ls   <= 1'b0;
      r_wr      <= 1'b0;
      r_first   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_len     <= '0;
      r_if_data <= '0;
      r_ls_data <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_hs_ls | w_hs_if) begin
          r_state <= ACCESS;
          r_cnt   <= 4'(LAT - 1);
          r_is_ls <= w_hs_ls;
          r_wr    <= w_hs_ls & bus.iLsReqWrEn;
          r_first <= 1'b1;
          r_addr  <= w_hs_ls ? bus.iLsReqAddr : bus.iIfReqAddr;
          r_data  <= w_hs_ls ? bus.iLsReqData : '0;
          r_len   <= w_hs_ls ? bus.iLsReqLen : 8'd4;
        end
        ACCESS: begin
          r_first <= 1'b0;
          r_cnt   <= r_cnt - 4'd1;
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
            if (r_is_ls) r_ls_data <= r_wr ? '0 : bus.iMemRdData & w_mask;
            else r_if_data <= bus.iMemRdData[31:0];
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with LAT=1 and LAT=3 instances
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b1 ();
  mem_arbiter_if #(.ADDR_W(64), .DATA_W(64)) b3 ();
  mem_arbiter #(.LAT(1), .ADDR_W(64), .DATA_W(64)) u1 (.iClock(clk), .iReset(rst), .bus(b1));
  mem_arbiter #(.LAT(3), .ADDR_W(64), .DATA_W(64)) u3 (.iClock(clk), .iReset(rst), .bus(b3));
  typedef struct {logic ls; logic [63:0] data;} exp_t;
  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  task automatic idle_inputs();
    b1.iIfReqValid = 0; b1.iIfReqAddr = '0; b1.iLsReqValid = 0; b1.iLsReqWrEn = 0;
    b1.iLsReqAddr = '0; b1.iLsReqData = '0; b1.iLsReqLen = '0; b1.iMemRdData = '0;
    b3.iIfReqValid = 0; b3.iIfReqAddr = '0; b3.iLsReqValid = 0; b3.iLsReqWrEn = 0;
    b3.iLsReqAddr = '0; b3.iLsReqData = '0; b3.iLsReqLen = '0; b3.iMemRdData = '0;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask
  task automatic test_reset();
    logic any1, any3;
    do_reset();
    @(negedge clk);
    any1 = |{b1.oIfReqReady, b1.oIfRspValid, b1.oIfRspData, b1.oLsReqReady, b1.oLsRspValid, b1.oLsRspData,
             b1.oMemRdEn, b1.oMemRdAddr, b1.oMemRdLen, b1.oMemWrEn, b1.oMemWrAddr, b1.oMemWrData, b1.oMemWrLen, b1.oBusy};
    any3 = |{b3.oIfReqReady, b3.oIfRspValid, b3.oIfRspData, b3.oLsReqReady, b3.oLsRspValid, b3.oLsRspData,
             b3.oMemRdEn, b3.oMemRdAddr, b3.oMemRdLen, b3.oMemWrEn, b3.oMemWrAddr, b3.oMemWrData, b3.oMemWrLen, b3.oBusy};
    checks++;
    if (any1 !== 1'b0) begin failures++; $display("FAIL reset_outputs_lat1 got=%b exp=0", any1); end
    checks++;
    if (any3 !== 1'b0) begin failures++; $display("FAIL reset_outputs_lat3 got=%b exp=0", any3); end
  endtask
  task automatic test_if_read();
    int rd_cnt = 0, rsp_cnt = 0;
    @(posedge clk); #1;
    b1.iIfReqValid = 1; b1.iIfReqAddr = 64'h8000_0000; b1.iMemRdData = 64'h1234_5678_0000_0013;
    @(negedge clk);
    checks++;
    if ({b1.oIfReqReady, b1.oLsReqReady} !== 2'b10) begin failures++; $display("FAIL if_ready got=%b exp=10", {b1.oIfReqReady, b1.oLsReqReady}); end
    q.push_back('{ls: 1'b0, data: 64'h13});
    @(posedge clk); #1 b1.iIfReqValid = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (b1.oMemRdEn) rd_cnt++;
      if (k == 1) begin
        checks++;
        if ({b1.oMemRdAddr, b1.oMemRdLen} !== {64'h8000_0000, 8'd4}) begin failures++; $display("FAIL if_rd_pins got=%h/%0d exp=80000000/4", b1.oMemRdAddr, b1.oMemRdLen); end
      end
      if (b1.oIfRspValid) begin
        rsp_cnt++;
        e = q.pop_front();
        checks++;
        if (k !== 2) begin failures++; $display("FAIL if_latency got=%0d exp=2", k); end
        checks++;
        if (b1.oIfRspData !== e.data[31:0]) begin failures++; $display("FAIL if_data got=%h exp=%h", b1.oIfRspData, e.data[31:0]); end
      end
    end
    checks++;
    if (rd_cnt !== 1) begin failures++; $display("FAIL if_rden_cycles got=%0d exp=1", rd_cnt); end
    checks++;
    if (rsp_cnt !== 1 || q.size() != 0) begin failures++; $display("FAIL if_rsp_count got=%0d exp=1", rsp_cnt); end
    q.delete();
  endtask
  task automatic test_ls_load();
    int rd_cnt = 0, rsp_cnt = 0;
    @(posedge clk); #1;
    b3.iLsReqValid = 1; b3.iLsReqWrEn = 0; b3.iLsReqAddr = 64'h8000_0100; b3.iLsReqLen = 8'd2;
    b3.iMemRdData = 64'hFFFF_FFFF_FFFF_ABCD;
    q.push_back('{ls: 1'b1, data: 64'hABCD});
    @(posedge clk); #1 b3.iLsReqValid = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (b3.oMemRdEn) begin
        rd_cnt++;
        checks++;
        if ({b3.oMemRdAddr, b3.oMemRdLen} !== {64'h8000_0100, 8'd2}) begin failures++; $display("FAIL ld_rd_pins got=%h/%0d exp=80000100/2", b3.oMemRdAddr, b3.oMemRdLen); end
      end
      if (b3.oLsRspValid) begin
        rsp_cnt++;
        e = q.pop_front();
        checks++;
        if (k !== 4) begin failures++; $display("FAIL ld_latency got=%0d exp=4", k); end
        checks++;
        if (b3.oLsRspData !== e.data) begin failures++; $display("FAIL ld_data got=%h exp=%h", b3.oLsRspData, e.data); end
      end
    end
    checks++;
    if (rd_cnt !== 3) begin failures++; $display("FAIL ld_rden_cycles got=%0d exp=3", rd_cnt); end
    checks++;
    if (rsp_cnt !== 1 || q.size() != 0) begin failures++; $display("FAIL ld_rsp_count got=%0d exp=1", rsp_cnt); end
    q.delete();
  endtask
  task automatic test_ls_store();
    int wr_cnt = 0, rsp_cnt = 0;
    @(posedge clk); #1;
    b3.iLsReqValid = 1; b3.iLsReqWrEn = 1; b3.iLsReqAddr = 64'h8000_0200; b3.iLsReqData = 64'hDEAD_BEEF;
    b3.iLsReqLen = 8'd4; b3.iMemRdData = 64'h5555_5555_5555_5555;
    q.push_back('{ls: 1'b1, data: 64'h0});
    @(posedge clk); #1 b3.iLsReqValid = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (b3.oMemWrEn) begin
        wr_cnt++;
        checks++;
        if ({b3.oMemWrAddr, b3.oMemWrData, b3.oMemWrLen} !== {64'h8000_0200, 64'hDEAD_BEEF, 8'd4}) begin
          failures++; $display("FAIL st_wr_pins got=%h/%h/%0d exp=80000200/deadbeef/4", b3.oMemWrAddr, b3.oMemWrData, b3.oMemWrLen);
        end
      end
      if (b3.oMemRdEn) begin failures++; checks++; $display("FAIL st_rden got=1 exp=0"); end
      if (b3.oLsRspValid) begin
        rsp_cnt++;
        e = q.pop_front();
        checks++;
        if (k !== 4) begin failures++; $display("FAIL st_latency got=%0d exp=4", k); end
        checks++;
        if (b3.oLsRspData !== e.data) begin failures++; $display("FAIL st_data got=%h exp=%h", b3.oLsRspData, e.data); end
      end
    end
    checks++;
    if (wr_cnt !== 1) begin failures++; $display("FAIL st_wren_cycles got=%0d exp=1", wr_cnt); end
    checks++;
    if (rsp_cnt !== 1 || q.size() != 0) begin failures++; $display("FAIL st_rsp_count got=%0d exp=1", rsp_cnt); end
    b3.iLsReqWrEn = 0;
    q.delete();
  endtask
  task automatic test_arbitration();
    int grants = 0, rsps = 0;
    logic exp_ls;
    do_reset();
    b1.iIfReqValid = 1; b1.iIfReqAddr = 64'h8000_1000;
    b1.iLsReqValid = 1; b1.iLsReqWrEn = 0; b1.iLsReqAddr = 64'h8000_2000; b1.iLsReqLen = 8'd8;
    b1.iMemRdData = 64'h1122_3344_5566_7788;
    for (int k = 0; k < 40 && (grants < 4 || q.size() != 0); k++) begin
      @(negedge clk);
      if (b1.oIfReqReady & b1.oLsReqReady) begin failures++; checks++; $display("FAIL arb_both_ready got=11 exp=one-hot"); end
      if (b1.oIfReqReady | b1.oLsReqReady) begin
`ifdef MEM_ARB_RR_EN
        exp_ls = (grants % 2) == 0;
`else
        exp_ls = 1'b1;
`endif
        checks++;
        if (b1.oLsReqReady !== exp_ls) begin failures++; $display("FAIL arb_grant%0d got_ls=%b exp_ls=%b", grants, b1.oLsReqReady, exp_ls); end
        q.push_back('{ls: b1.oLsReqReady, data: b1.oLsReqReady ? 64'h1122_3344_5566_7788 : 64'h5566_7788});
        grants++;
      end
      if (b1.oIfRspValid | b1.oLsRspValid) begin
        rsps++;
        e = q.pop_front();
        checks++;
        if (b1.oLsRspValid !== e.ls || (e.ls ? b1.oLsRspData : {32'h0, b1.oIfRspData}) !== e.data) begin
          failures++; $display("FAIL arb_rsp got_ls=%b if=%h ls=%h exp_ls=%b data=%h", b1.oLsRspValid, b1.oIfRspData, b1.oLsRspData, e.ls, e.data);
        end
      end
      @(posedge clk); #1;
      if (grants == 4) begin b1.iIfReqValid = 0; b1.iLsReqValid = 0; end
    end
    checks++;
    if (grants !== 4 || rsps !== 4) begin failures++; $display("FAIL arb_count got=%0d/%0d exp=4/4", grants, rsps); end
    q.delete();
    idle_inputs();
  endtask
  task automatic test_reset_mid();
    int rsp_cnt = 0;
    logic any3;
    @(posedge clk); #1;
    b3.iLsReqValid = 1; b3.iLsReqAddr = 64'h8000_0300; b3.iLsReqLen = 8'd8; b3.iMemRdData = 64'hA5A5_A5A5_A5A5_A5A5;
    @(posedge clk); #1 b3.iLsReqValid = 0;
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    any3 = |{b3.oIfReqReady, b3.oIfRspValid, b3.oIfRspData, b3.oLsReqReady, b3.oLsRspValid, b3.oLsRspData,
             b3.oMemRdEn, b3.oMemRdAddr, b3.oMemRdLen, b3.oMemWrEn, b3.oMemWrAddr, b3.oMemWrData, b3.oMemWrLen, b3.oBusy};
    checks++;
    if (any3 !== 1'b0) begin failures++; $display("FAIL midrst_outputs got=%b exp=0 busy=%b", any3, b3.oBusy); end
    repeat (6) begin
      @(negedge clk);
      if (b3.oLsRspValid) rsp_cnt++;
    end
    checks++;
    if (rsp_cnt !== 0) begin failures++; $display("FAIL midrst_dropped got=%0d exp=0", rsp_cnt); end
    @(posedge clk); #1;
    b3.iIfReqValid = 1; b3.iIfReqAddr = 64'h8000_0400; b3.iMemRdData = 64'h0000_0000_CAFE_F00D;
    q.push_back('{ls: 1'b0, data: 64'hCAFE_F00D});
    @(posedge clk); #1 b3.iIfReqValid = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      if (b3.oIfRspValid) begin
        e = q.pop_front();
        checks++;
        if (k !== 4 || b3.oIfRspData !== e.data[31:0]) begin
          failures++; $display("FAIL midrst_if_rsp got=%0d/%h exp=4/%h", k, b3.oIfRspData, e.data[31:0]);
        end
      end
    end
    checks++;
    if (q.size() != 0) begin failures++; $display("FAIL midrst_if_missing got=%0d exp=0", q.size()); end
    q.delete();
  endtask
  task automatic test_back_to_back();
    int hs[$];
    @(posedge clk); #1;
    b1.iIfReqValid = 1; b1.iIfReqAddr = 64'h8000_0500; b1.iMemRdData = 64'h0000_0000_0BAD_C0DE;
    for (int k = 0; k < 30 && (hs.size() < 3 || q.size() != 0); k++) begin
      @(negedge clk);
      if (b1.oBusy && b1.oIfReqReady) begin failures++; checks++; $display("FAIL b2b_ready_busy got=1 exp=0"); end
      if (b1.oIfReqReady) begin
        hs.push_back(k);
        q.push_back('{ls: 1'b0, data: 64'h0BAD_C0DE});
      end
      if (b1.oIfRspValid) begin
        e = q.pop_front();
        checks++;
        if (b1.oIfRspData !== e.data[31:0]) begin failures++; $display("FAIL b2b_data got=%h exp=%h", b1.oIfRspData, e.data[31:0]); end
      end
      @(posedge clk); #1;
      if (hs.size() == 3) b1.iIfReqValid = 0;
    end
    checks++;
    if (hs.size() != 3) begin failures++; $display("FAIL b2b_handshakes got=%0d exp=3", hs.size()); end
    else begin
      checks++;
      if (hs[1] - hs[0] !== 3 || hs[2] - hs[1] !== 3) begin
        failures++; $display("FAIL b2b_spacing got=%0d,%0d exp=3,3", hs[1] - hs[0], hs[2] - hs[1]);
      end
    end
    q.delete();
  endtask
  initial begin
    test_reset();
    test_if_read();
    test_ls_load();
    test_ls_store();
    test_arbitration();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
